pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 32: multiply/divide unit latency in cycles, range 2..63.
REQ-002 Parameter STAT_W, default 16: width of the stall statistics counter.
REQ-003 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 ID_Rs  input  5  source register of the instruction in ID.
REQ-006 ID_Rt  input  5  second source register of the instruction in ID.
REQ-007 EX_WR_out  input  5  destination register of the instruction in EX.
REQ-008 EX_MemtoReg  input  1  EX instruction is a load.
REQ-009 EX_JumpOP  input  2  nonzero = taken branch/jump resolved in EX.
REQ-010 ID_MDOp  input  1  ID instruction is mult/div.
REQ-011 ID_HiLoRd  input  1  ID instruction reads HI/LO (mfhi/mflo).
REQ-012 DM_Busy  input  1  data memory not ready this cycle.
REQ-013 PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite  output  1 each  pipeline register write enables.
REQ-014 IF_Flush, ID_Flush  output  1 each  squash IF/ID and ID/EX contents.
REQ-015 MD_Start  output  1  one-cycle issue pulse to the mult/div unit.
REQ-016 MD_Busy  output  1  mult/div operation in flight.
REQ-017 StallCount  output  STAT_W  number of cycles with PCWrite=0, saturating.

Function
REQ-018 FSM states SHALL be RUN and MD_BUSY; down-counter md_cnt is 6 bits wide.
REQ-019 Default outputs SHALL be: all write enables 1, flushes 0, MD_Start 0.
REQ-020 Load-use hazard SHALL be EX_MemtoReg=1 and EX_WR_out!=0 and EX_WR_out equals ID_Rs or ID_Rt; response: PCWrite=0, IF_IDWrite=0, ID_Flush=1.
REQ-021 MD hazard SHALL be state MD_BUSY and (ID_MDOp or ID_HiLoRd); response identical to REQ-020.
REQ-022 Taken branch (EX_JumpOP!=0) SHALL assert IF_Flush=1 and ID_Flush=1 and SHALL force PCWrite=1 and IF_IDWrite=1, overriding REQ-020/021.
REQ-023 DM_Busy=1 SHALL override everything: all four write enables 0, both flushes 0, MD_Start 0.
REQ-024 MD_Start SHALL be 1 when ID_MDOp=1, state RUN, DM_Busy=0, no taken branch, and no load-use hazard.
REQ-025 On MD_Start, the FSM SHALL go RUN->MD_BUSY and load md_cnt=MD_CYCLES-1.
REQ-026 In MD_BUSY, md_cnt SHALL decrement every cycle regardless of DM_Busy or flushes; at md_cnt=0 the FSM SHALL return to RUN on the next edge.
REQ-027 A branch flush during MD_BUSY SHALL NOT abort the in-flight operation.
REQ-028 MD_Busy SHALL equal 1 exactly when state is MD_BUSY; MD_Start to MD_Busy fall SHALL be MD_CYCLES cycles.
REQ-029 StallCount SHALL increment on each edge where PCWrite=0 and SHALL hold at all-ones.
REQ-030 Outputs other than StallCount and MD_Busy SHALL be combinational from inputs and state, with no added latency.

Reset
REQ-031 While rst=0: state=RUN, md_cnt=0, StallCount=0, MD_Busy=0, MD_Start=0, all write enables 0, and both flushes 0.
REQ-032 Reset asserted mid-operation SHALL abandon MD_BUSY immediately; after release the FSM SHALL be in RUN.

Structure
REQ-033 Package pipe_pkg SHALL hold the state encoding, MD_CYCLES default, and width constants.
REQ-034 The MD latency counter SHALL be a sub-module pipe_md_timer with inputs load and value and output busy; the hazard decode SHALL stay in pipe_ctrl.

Verification
REQ-035 The bench SHALL cover EX_MemtoReg=1, EX_WR_out=5, ID_Rs=5 -> PCWrite=0, IF_IDWrite=0, ID_Flush=1, and StallCount increments by 1.
REQ-036 The bench SHALL cover EX_MemtoReg=1, EX_WR_out=0, ID_Rt=0 -> no stall and all enables 1.
REQ-037 The bench SHALL cover load-use on ID_Rs plus EX_JumpOP=2'b01 in the same cycle -> PCWrite=1, IF_Flush=1, ID_Flush=1.
REQ-038 The bench SHALL cover ID_MDOp pulse with MD_CYCLES=4 -> MD_Start one cycle and MD_Busy high exactly 4 cycles; ID_HiLoRd in cycle 2 -> stalled until MD_Busy falls.
REQ-039 The bench SHALL cover DM_Busy=1 for 3 cycles during MD_BUSY -> all enables 0 and md_cnt still expires on schedule.
REQ-040 The bench SHALL cover rst=0 asserted during MD_BUSY -> MD_Busy=0 and StallCount=0 asynchronously, then RUN after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package pipe_pkg;

  localparam int MD_CYCLES_DEF = 32;
  localparam int STAT_W_DEF    = 16;
  localparam int REG_W         = 5;
  localparam int JUMP_W        = 2;
  localparam int MD_CNT_W      = 6;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side signals of the hazard controller: decode/EX inputs and stage controls.
interface pipe_ctrl_if
  import pipe_pkg::*;
#(
  parameter int STAT_W = STAT_W_DEF
);

  logic [REG_W-1:0]  ID_Rs;
  logic [REG_W-1:0]  ID_Rt;
  logic [REG_W-1:0]  EX_WR_out;
  logic              EX_MemtoReg;
  logic [JUMP_W-1:0] EX_JumpOP;
  logic              ID_MDOp;
  logic              ID_HiLoRd;
  logic              DM_Busy;

  logic              PCWrite;
  logic              IF_IDWrite;
  logic              ID_EXWrite;
  logic              EX_MEMWrite;
  logic              IF_Flush;
  logic              ID_Flush;
  logic              MD_Start;
  logic              MD_Busy;
  logic [STAT_W-1:0] StallCount;

  modport master (
    output ID_Rs, ID_Rt, EX_WR_out, EX_MemtoReg, EX_JumpOP, ID_MDOp, ID_HiLoRd, DM_Busy,
    input  PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, IF_Flush, ID_Flush,
           MD_Start, MD_Busy, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, EX_WR_out, EX_MemtoReg, EX_JumpOP, ID_MDOp, ID_HiLoRd, DM_Busy,
    output PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, IF_Flush, ID_Flush,
           MD_Start, MD_Busy, StallCount
  );

endinterface

// File: rtl/pipe_md_timer.sv
// Mult/div latency down-counter; busy while the count has not reached terminal zero.
module pipe_md_timer
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] value,
  output logic                busy
);

  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use and mult/div interlocks, branch flush,
// memory-wait freeze, and a saturating stall statistic.
//
//   state   | meaning
//   RUN     | no mult/div in flight; an ID mult/div may issue
//   MD_BUSY | mult/div in flight; HI/LO readers and new mult/div stall
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int STAT_W    = STAT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic              md_busy_q, md_busy_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  logic load_use, md_hazard, taken, md_start, tmr_busy;
  logic pc_wr, ifid_wr, idex_wr, exmem_wr, if_flush, id_flush;

  always_comb begin
    load_use  = bus.EX_MemtoReg && (bus.EX_WR_out != '0) &&
                ((bus.EX_WR_out == bus.ID_Rs) || (bus.EX_WR_out == bus.ID_Rt));
    md_hazard = (state_q == MD_BUSY) && (bus.ID_MDOp || bus.ID_HiLoRd);
    taken     = (bus.EX_JumpOP != '0);

    pc_wr    = 1'b1;
    ifid_wr  = 1'b1;
    idex_wr  = 1'b1;
    exmem_wr = 1'b1;
    if_flush = 1'b0;
    id_flush = 1'b0;
    md_start = bus.ID_MDOp && (state_q == RUN) && !bus.DM_Busy && !taken && !load_use;

    if (load_use || md_hazard) begin
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      id_flush = 1'b1;
    end
    // A taken branch discards the stalled instruction anyway, so it wins over the interlock.
    if (taken) begin
      pc_wr    = 1'b1;
      ifid_wr  = 1'b1;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end
    if (bus.DM_Busy) begin
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      idex_wr  = 1'b0;
      exmem_wr = 1'b0;
      if_flush = 1'b0;
      id_flush = 1'b0;
    end
    if (!rst) begin
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      idex_wr  = 1'b0;
      exmem_wr = 1'b0;
      if_flush = 1'b0;
      id_flush = 1'b0;
      md_start = 1'b0;
    end
  end

  // The timer keeps counting through memory waits and flushes; only reset aborts it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (md_start) state_d = MD_BUSY;
      MD_BUSY: if (!tmr_busy) state_d = RUN;
      default: state_d = RUN;
    endcase
    md_busy_d = (state_d == MD_BUSY);
    stall_d   = stall_q;
    if (!pc_wr && (stall_q != '1)) begin
      stall_d = stall_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      md_busy_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      md_busy_q <= md_busy_d;
      stall_q   <= stall_d;
    end
  end

  pipe_md_timer u_md_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (md_start),
    .value (MD_CNT_W'(MD_CYCLES - 1)),
    .busy  (tmr_busy)
  );

  assign bus.PCWrite     = pc_wr;
  assign bus.IF_IDWrite  = ifid_wr;
  assign bus.ID_EXWrite  = idex_wr;
  assign bus.EX_MEMWrite = exmem_wr;
  assign bus.IF_Flush    = if_flush;
  assign bus.ID_Flush    = id_flush;
  assign bus.MD_Start    = md_start;
  assign bus.MD_Busy     = md_busy_q;
  assign bus.StallCount  = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors with hand-computed outputs.
module tb_pipe_ctrl;

  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAT_W(SW)) bus ();

  pipe_ctrl #(.MD_CYCLES(4), .STAT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]    outs;
    logic [SW-1:0] stall;
    string         name;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // outs = {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, IF_Flush, ID_Flush, MD_Start, MD_Busy}
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] wr, input logic mtr, input logic [1:0] jop,
                      input logic mdop, input logic hilo, input logic dmb,
                      input logic [7:0] exp_o, input logic [SW-1:0] exp_s, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.ID_Rs       = rs;
    bus.ID_Rt       = rt;
    bus.EX_WR_out   = wr;
    bus.EX_MemtoReg = mtr;
    bus.EX_JumpOP   = jop;
    bus.ID_MDOp     = mdop;
    bus.ID_HiLoRd   = hilo;
    bus.DM_Busy     = dmb;
    e.outs  = exp_o;
    e.stall = exp_s;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      logic [7:0] got;
      e   = sb_q.pop_front();
      got = {bus.PCWrite, bus.IF_IDWrite, bus.ID_EXWrite, bus.EX_MEMWrite,
             bus.IF_Flush, bus.ID_Flush, bus.MD_Start, bus.MD_Busy};
      chk_cnt++;
      if (got === e.outs && bus.StallCount === e.stall) begin
        pass_cnt++;
      end else begin
        $display("FAIL %s: got outs=%b stall=%0d, expected outs=%b stall=%0d",
                 e.name, got, bus.StallCount, e.outs, e.stall);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    bus.ID_Rs = '0; bus.ID_Rt = '0; bus.EX_WR_out = '0; bus.EX_MemtoReg = 1'b0;
    bus.EX_JumpOP = '0; bus.ID_MDOp = 1'b0; bus.ID_HiLoRd = 1'b0; bus.DM_Busy = 1'b0;

    //    rst rs  rt  wr  mtr jop    md hl dm  outs   stall
    step(0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 8'h00, 0, "reset");
    step(1, 1,  2,  3,  0, 2'b00, 0, 0, 0, 8'hF0, 0, "nop");
    step(1, 5,  0,  5,  1, 2'b00, 0, 0, 0, 8'h34, 0, "load_use_rs");
    step(1, 0,  0,  0,  0, 2'b00, 0, 0, 0, 8'hF0, 1, "stall_inc");
    step(1, 7,  0,  0,  1, 2'b00, 0, 0, 0, 8'hF0, 1, "load_r0_no_stall");
    step(1, 5,  0,  5,  1, 2'b01, 0, 0, 0, 8'hFC, 1, "branch_over_load_use");
    step(1, 0,  9,  9,  1, 2'b00, 0, 0, 0, 8'h34, 1, "load_use_rt");
    step(1, 0,  0,  0,  0, 2'b00, 1, 0, 0, 8'hF2, 2, "md_start");
    step(1, 0,  0,  0,  0, 2'b00, 0, 0, 0, 8'hF1, 2, "md_busy_c1");
    step(1, 0,  0,  0,  0, 2'b00, 0, 1, 0, 8'h35, 2, "hilo_stall_c2");
    step(1, 0,  0,  0,  0, 2'b00, 0, 1, 0, 8'h35, 3, "hilo_stall_c3");
    step(1, 0,  0,  0,  0, 2'b00, 0, 1, 0, 8'h35, 4, "hilo_stall_c4");
    step(1, 0,  0,  0,  0, 2'b00, 0, 1, 0, 8'hF0, 5, "hilo_release");
    step(1, 0,  0,  0,  0, 2'b00, 1, 0, 0, 8'hF2, 5, "md_start_2");
    step(1, 0,  0,  0,  0, 2'b00, 0, 0, 1, 8'h01, 5, "dm_busy_1");
    step(1, 0,  0,  0,  0, 2'b01, 0, 0, 1, 8'h01, 6, "dm_busy_over_branch");
    step(1, 0,  0,  0,  0, 2'b00, 1, 0, 1, 8'h01, 7, "dm_busy_saturate");
    step(1, 0,  0,  0,  0, 2'b01, 0, 0, 0, 8'hFD, 7, "branch_in_md_busy");
    step(1, 0,  0,  0,  0, 2'b00, 0, 0, 0, 8'hF0, 7, "md_expired");
    step(1, 0,  0,  0,  0, 2'b00, 1, 0, 0, 8'hF2, 7, "md_start_3");
    step(1, 0,  0,  0,  0, 2'b00, 0, 0, 0, 8'hF1, 7, "md_busy_pre_rst");
    step(0, 0,  0,  0,  0, 2'b00, 0, 0, 0, 8'h00, 0, "async_reset");
    step(1, 0,  0,  0,  0, 2'b00, 0, 1, 0, 8'hF0, 0, "run_after_rst");
    step(1, 0,  0,  0,  0, 2'b00, 1, 0, 0, 8'hF2, 0, "md_start_after_rst");
    step(1, 0,  0,  0,  0, 2'b00, 0, 0, 0, 8'hF1, 0, "md_busy_after_rst");

    repeat (2) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
